// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath stages: default word width and the
// signed compare / clamp helpers used by convolution and pooling layers.
package cnn_pkg;

    localparam int DEF_DATA_W = 32;

    // Helpers work on a wide signed word; callers sign-extend into it and
    // truncate back, so one pair of functions serves any DATA_W up to 64.
    localparam int CALC_W = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic calc_t smax(input calc_t a, input calc_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic calc_t relu(input calc_t x);
        return x[CALC_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Partial-max line buffer for 2x2 pooling: one word per output column,
// synchronous write, asynchronous read on a shared address.
module pool_line_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_maxpool2d.sv
// 2x2 stride-2 max pooling with optional ReLU on a row-major pixel stream,
// using a half-width line buffer of horizontal pair maxima.
module conv_maxpool2d
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int RELU   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] hmax;
    logic [DATA_W-1:0] lb_rdata;
    logic [AW-1:0]     lb_addr;
    logic              lb_we;
    logic              xfer;
    logic              col_last;
    logic              row_last;

    calc_t v;
    calc_t hmax_x;
    calc_t lb_x;
    calc_t pair;
    calc_t pooled;

    assign in_ready = en && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign lb_addr  = AW'(col >> 1);

    always_comb begin
        v = CALC_W'(signed'(in_data));
        if (RELU != 0) begin
            v = relu(v);
        end
        hmax_x = CALC_W'(signed'(hmax));
        lb_x   = CALC_W'(signed'(lb_rdata));
        pair   = smax(hmax_x, v);
        pooled = smax(lb_x, pair);
    end

    // Top row of each window parks its pair max; the bottom row consumes it.
    assign lb_we = xfer && col[0] && !row[0];

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_line_buf (
        .clk    (clk),
        .we     (lb_we),
        .addr   (lb_addr),
        .wdata  (DATA_W'(pair)),
        .rdata  (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            hmax      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer) begin
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) begin
                    row <= row_last ? '0 : row + RW'(1);
                end
                if (!col[0]) begin
                    hmax <= DATA_W'(v);
                end else if (row[0]) begin
                    // Loading here overrides the clear above when both happen.
                    out_data  <= DATA_W'(pooled);
                    out_valid <= 1'b1;
                    out_last  <= col_last && row_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_maxpool2d.sv
// Directed bench for conv_maxpool2d: 4x4 ReLU instance plus a pair of 4x2
// instances (ReLU on/off) driven with the same negative-valued frame.
module tb_conv_maxpool2d;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        en_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
    logic [31:0] in_data_a, out_data_a;

    logic        en_b, in_valid_b, out_ready_b;
    logic [31:0] in_data_b;
    logic        in_ready_b, out_valid_b, out_last_b;
    logic [31:0] out_data_b;
    logic        in_ready_c, out_valid_c, out_last_c;
    logic [31:0] out_data_c;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_q[$];
    logic        last_q[$];

    conv_maxpool2d #(.DATA_W(32), .IMG_W(4), .IMG_H(4), .RELU(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_last(out_last_a)
    );

    conv_maxpool2d #(.DATA_W(32), .IMG_W(4), .IMG_H(2), .RELU(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_last(out_last_b)
    );

    conv_maxpool2d #(.DATA_W(32), .IMG_W(4), .IMG_H(2), .RELU(0)) dut_c (
        .clk(clk), .rst(rst), .en(en_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_c), .out_data(out_data_c), .out_valid(out_valid_c),
        .out_ready(out_ready_b), .out_last(out_last_c)
    );

    // One cycle on dut_a: drive at the falling edge, observe just after it.
    task automatic step_a(input logic en, input logic ordy, input logic vld, input logic [31:0] d,
                          output logic acc, output logic val, output logic [31:0] od, output logic ol);
        @(negedge clk);
        en_a = en; out_ready_a = ordy; in_valid_a = vld; in_data_a = d;
        #1;
        acc = vld && in_ready_a;
        val = out_valid_a;
        od  = out_data_a;
        ol  = out_last_a;
        if (out_valid_a && ordy) begin
            got_q.push_back(out_data_a);
            last_q.push_back(out_last_a);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        got_q.delete();
        last_q.delete();
    endtask

    task automatic test_reset();
        en_a = 1'b1; out_ready_a = 1'b0;
        apply_reset();
        #1;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid_a); end
        total++; if (out_data_a !== 32'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", out_data_a); end
        total++; if (out_last_a !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last_a); end
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_a); end
        total++; if (out_valid_c !== 1'b0) begin bad++; $display("FAIL reset_valid_c got=%b want=0", out_valid_c); end
    endtask

    task automatic test_basic();
        logic acc, val, ol;
        logic [31:0] od;
        logic [31:0] exp_v [4];
        int idx = 0;
        int acc_step = -1;
        int vis_step = -1;
        exp_v = '{32'd6, 32'd8, 32'd14, 32'd16};
        got_q.delete(); last_q.delete();
        for (int cyc = 0; cyc < 200 && got_q.size() < 4; cyc++) begin
            step_a(1'b1, 1'b1, idx < 16, idx + 1, acc, val, od, ol);
            if (val && vis_step < 0) vis_step = cyc;
            if (acc) begin
                if (idx == 5) acc_step = cyc;
                idx++;
            end
        end
        step_a(1'b1, 1'b1, 1'b0, 32'd0, acc, val, od, ol);
        total++; if (vis_step - acc_step != 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", vis_step - acc_step); end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL basic_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_v[i]) begin bad++; $display("FAIL basic_val[%0d] got=%0d want=%0d", i, got_q[i], exp_v[i]); end
            total++; if (last_q[i] !== (i == 3)) begin bad++; $display("FAIL basic_last[%0d] got=%b want=%b", i, last_q[i], i == 3); end
        end
    endtask

    task automatic test_stall();
        logic acc, val, ol, ordy;
        logic [31:0] od;
        logic [31:0] exp_v [4];
        int idx = 0;
        int stall = 0;
        exp_v = '{32'd6, 32'd8, 32'd14, 32'd16};
        got_q.delete(); last_q.delete();
        for (int cyc = 0; cyc < 300 && got_q.size() < 4; cyc++) begin
            ordy = (stall >= 5);
            step_a(1'b1, ordy, idx < 16, idx + 1, acc, val, od, ol);
            if (val && !ordy) begin
                stall++;
                total++; if (acc !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b want=0", stall, acc); end
                total++; if (od !== 32'd6 || ol !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d] got=%0d/%b want=6/0", stall, od, ol); end
            end
            if (acc) idx++;
        end
        step_a(1'b1, 1'b1, 1'b0, 32'd0, acc, val, od, ol);
        total++; if (stall != 5) begin bad++; $display("FAIL stall_cycles got=%0d want=5", stall); end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_v[i] || last_q[i] !== (i == 3)) begin
                bad++; $display("FAIL stall_val[%0d] got=%0d/%b want=%0d/%b", i, got_q[i], last_q[i], exp_v[i], i == 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic acc, val, ol;
        logic [31:0] od;
        logic [31:0] exp_v [4];
        int idx = 0;
        exp_v = '{32'd6, 32'd8, 32'd14, 32'd16};
        for (int cyc = 0; cyc < 50 && idx < 6; cyc++) begin
            step_a(1'b1, 1'b1, 1'b1, 32'd101 + idx, acc, val, od, ol);
            if (acc) idx++;
        end
        apply_reset();
        #1;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", out_valid_a); end
        idx = 0;
        for (int cyc = 0; cyc < 200 && (idx < 16 || got_q.size() < 4); cyc++) begin
            step_a(1'b1, 1'b1, idx < 16, idx + 1, acc, val, od, ol);
            if (acc) idx++;
        end
        repeat (6) step_a(1'b1, 1'b1, 1'b0, 32'd0, acc, val, od, ol);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL midreset_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_v[i] || last_q[i] !== (i == 3)) begin
                bad++; $display("FAIL midreset_val[%0d] got=%0d/%b want=%0d/%b", i, got_q[i], last_q[i], exp_v[i], i == 3);
            end
        end
    endtask

    task automatic test_relu();
        logic [31:0] pix [8];
        logic [31:0] qb[$];
        logic [31:0] qc[$];
        logic        lb[$];
        logic        lc[$];
        int idx = 0;
        pix = '{-32'sd5, -32'sd3, -32'sd7, -32'sd1, -32'sd2, -32'sd9, -32'sd4, -32'sd6};
        for (int cyc = 0; cyc < 100 && (qb.size() < 2 || qc.size() < 2); cyc++) begin
            @(negedge clk);
            en_b = 1'b1; out_ready_b = 1'b1;
            in_valid_b = (idx < 8);
            in_data_b = (idx < 8) ? pix[idx] : 32'd0;
            #1;
            if (out_valid_b) begin qb.push_back(out_data_b); lb.push_back(out_last_b); end
            if (out_valid_c) begin qc.push_back(out_data_c); lc.push_back(out_last_c); end
            if (in_valid_b && in_ready_b && in_ready_c) idx++;
        end
        @(negedge clk); in_valid_b = 1'b0;
        total++; if (qb.size() != 2 || qc.size() != 2) begin bad++; $display("FAIL relu_count got=%0d/%0d want=2/2", qb.size(), qc.size()); end
        if (qb.size() == 2 && qc.size() == 2) begin
            total++; if (qb[0] !== 32'd0 || qb[1] !== 32'd0) begin bad++; $display("FAIL relu_on got=%0d,%0d want=0,0", $signed(qb[0]), $signed(qb[1])); end
            total++; if (qc[0] !== 32'hFFFF_FFFE || qc[1] !== 32'hFFFF_FFFF) begin
                bad++; $display("FAIL relu_off got=%0d,%0d want=-2,-1", $signed(qc[0]), $signed(qc[1]));
            end
            total++; if (lb[0] !== 1'b0 || lb[1] !== 1'b1 || lc[0] !== 1'b0 || lc[1] !== 1'b1) begin
                bad++; $display("FAIL relu_last got=%b%b/%b%b want=01/01", lb[0], lb[1], lc[0], lc[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc, val, ol, en, ordy;
        logic [31:0] od;
        logic        p_val = 1'b0, p_ordy = 1'b1, p_ol = 1'b0;
        logic [31:0] p_od = '0;
        logic [31:0] exp_v [8];
        int idx = 0;
        exp_v = '{32'd6, 32'd8, 32'd14, 32'd16, 32'd22, 32'd24, 32'd30, 32'd32};
        got_q.delete(); last_q.delete();
        for (int cyc = 0; cyc < 1500 && got_q.size() < 8; cyc++) begin
            en   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            step_a(en, ordy, idx < 32, idx + 1, acc, val, od, ol);
            if (!en) begin
                total++; if (acc !== 1'b0) begin bad++; $display("FAIL b2b_en_low cyc=%0d got=%b want=0", cyc, acc); end
            end
            if (p_val && !p_ordy) begin
                total++; if (val !== 1'b1 || od !== p_od || ol !== p_ol) begin
                    bad++; $display("FAIL b2b_hold cyc=%0d got=%b/%0d/%b want=1/%0d/%b", cyc, val, od, ol, p_od, p_ol);
                end
            end
            p_val = val; p_ordy = ordy; p_od = od; p_ol = ol;
            if (acc) idx++;
        end
        step_a(1'b1, 1'b1, 1'b0, 32'd0, acc, val, od, ol);
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_v[i] || last_q[i] !== (i == 3 || i == 7)) begin
                bad++; $display("FAIL b2b_val[%0d] got=%0d/%b want=%0d/%b", i, got_q[i], last_q[i], exp_v[i], i == 3 || i == 7);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        en_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
        en_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_relu();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
